irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer.sv | 148 ++++++++++++++
 tb/tb_irq_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - four-source interrupt sequencer with PENDING/STATUS/COUNT bus registers
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer ahead of edge detection.
module irq_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  irq_sources,
   input  logic [3:0]  irq_mask,
   output logic        irq_req,
   output logic [1:0]  irq_sel,
   input  logic        irq_ack,
   input  logic        irq_done,
   output logic        in_service,
   inout  wire  [31:0] data_bus_data,
   input  logic [31:0] data_bus_addr,
   input  logic [1:0]  data_bus_mode
);

   localparam logic [31:0] ADDR_PENDING = 32'h0000_4020;
   localparam logic [31:0] ADDR_STATUS  = 32'h0000_4024;
   localparam logic [31:0] ADDR_COUNT   = 32'h0000_4028;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_REQUEST    = 2'b01,
      ST_IN_SERVICE = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  src_q;
   logic [3:0]  pending_q, pending_d;
   logic [1:0]  sel_q, sel_d;
   logic [15:0] count_q, count_d;
   logic [3:0]  src_in;
   logic [3:0]  fall, active, ack_clr, wr_clr;
   logic [1:0]  top_idx;
   logic        ack_take;
   logic        bus_rd, bus_wr, rd_hit;
   logic [31:0] rdata;
   logic        unused_bus_bits;

`ifdef IRQ_SYNC_EN
   logic [3:0] sync1_q, sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
      end else begin
         sync1_q <= irq_sources;
         sync2_q <= sync1_q;
      end
   end
   assign src_in = sync2_q;
`else
   assign src_in = irq_sources;
`endif

   assign bus_rd = (data_bus_mode == 2'b01);
   assign bus_wr = (data_bus_mode == 2'b10);
   assign unused_bus_bits = ^data_bus_data[31:4];

   // Lines are active-low: a 1 -> 0 transition latches the request.
   assign fall   = src_q & ~src_in;
   assign active = pending_q & irq_mask;

   always_comb begin
      top_idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (active[i]) top_idx = i[1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      ack_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (active != 4'b0) begin
               state_d = ST_REQUEST;
               sel_d   = top_idx;
            end
         end
         ST_REQUEST: begin
            // An ack in the same cycle as a mask drop still wins.
            if (irq_ack) begin
               ack_take = 1'b1;
               state_d  = ST_IN_SERVICE;
            end else if (!irq_mask[sel_q]) begin
               state_d = ST_IDLE;
            end
         end
         ST_IN_SERVICE: begin
            if (irq_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      ack_clr   = ack_take ? (4'b0001 << sel_q) : 4'b0000;
      wr_clr    = (bus_wr && data_bus_addr == ADDR_PENDING) ? data_bus_data[3:0] : 4'b0000;
      pending_d = (pending_q & ~(ack_clr | wr_clr)) | fall;
   end

   always_comb begin
      count_d = count_q;
      if (bus_wr && data_bus_addr == ADDR_COUNT) begin
         count_d = 16'd0;
      end else if (ack_take && count_q != 16'hFFFF) begin
         count_d = count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         src_q     <= 4'hF;
         pending_q <= 4'h0;
         sel_q     <= 2'd0;
         count_q   <= 16'd0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_in;
         pending_q <= pending_d;
         sel_q     <= sel_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      rdata  = 32'd0;
      rd_hit = 1'b0;
      case (data_bus_addr)
         ADDR_PENDING: begin rdata = {28'd0, pending_q};               rd_hit = bus_rd; end
         ADDR_STATUS:  begin rdata = {26'd0, state_q, 2'b00, sel_q};   rd_hit = bus_rd; end
         ADDR_COUNT:   begin rdata = {16'd0, count_q};                 rd_hit = bus_rd; end
         default:      begin rdata = 32'd0;                            rd_hit = 1'b0;   end
      endcase
   end

   assign data_bus_data = rd_hit ? rdata : 32'hzzzz_zzzz;

   assign irq_req    = (state_q == ST_REQUEST);
   assign in_service = (state_q == ST_IN_SERVICE);
   assign irq_sel    = sel_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - randomized and directed checks of irq_sequencer against a behavioural model
module tb_irq_sequencer;

`ifdef IRQ_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  irq_sources;
   logic [3:0]  irq_mask;
   logic        irq_req;
   logic [1:0]  irq_sel;
   logic        irq_ack;
   logic        irq_done;
   logic        in_service;
   wire  [31:0] data_bus_data;
   logic [31:0] data_bus_addr;
   logic [1:0]  data_bus_mode;
   logic [31:0] drv;

   int total = 0;
   int bad   = 0;

   // Model: state 0 idle, 1 requesting, 2 servicing.
   int       m_state;
   int       m_sel;
   bit [3:0] m_pend;
   bit [3:0] m_prev;
   int       m_count;
   bit [3:0] m_pipe0, m_pipe1;

   assign data_bus_data = (data_bus_mode == 2'b10) ? drv : 32'hzzzz_zzzz;

   irq_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .irq_sources   (irq_sources),
      .irq_mask      (irq_mask),
      .irq_req       (irq_req),
      .irq_sel       (irq_sel),
      .irq_ack       (irq_ack),
      .irq_done      (irq_done),
      .in_service    (in_service),
      .data_bus_data (data_bus_data),
      .data_bus_addr (data_bus_addr),
      .data_bus_mode (data_bus_mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_sel   = 0;
      m_pend  = 4'h0;
      m_prev  = 4'hF;
      m_count = 0;
      m_pipe0 = 4'hF;
      m_pipe1 = 4'hF;
   endtask

   task automatic model_step();
      bit [3:0] seen;
      bit [3:0] newly;
      bit       accepted;
      int       old_sel;
      bit       wr_pend, wr_cnt;
`ifdef IRQ_SYNC_EN
      seen    = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = irq_sources;
`else
      seen = irq_sources;
`endif
      newly    = m_prev & ~seen;
      m_prev   = seen;
      accepted = 1'b0;
      old_sel  = m_sel;
      wr_pend  = (data_bus_mode == 2'b10) && (data_bus_addr == 32'h4020);
      wr_cnt   = (data_bus_mode == 2'b10) && (data_bus_addr == 32'h4028);
      if (m_state == 0) begin
         if ((m_pend & irq_mask) != 4'h0) begin
            m_state = 1;
            for (int i = 0; i < 4; i++) if (m_pend[i] && irq_mask[i]) m_sel = i;
         end
      end else if (m_state == 1) begin
         if (irq_ack) begin
            accepted = 1'b1;
            m_state  = 2;
         end else if (!irq_mask[m_sel]) begin
            m_state = 0;
         end
      end else begin
         if (irq_done) m_state = 0;
      end
      for (int i = 0; i < 4; i++) begin
         if (newly[i]) m_pend[i] = 1'b1;
         else if ((accepted && i == old_sel) || (wr_pend && drv[i])) m_pend[i] = 1'b0;
      end
      if (wr_cnt) m_count = 0;
      else if (accepted && m_count < 65535) m_count = m_count + 1;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (a)
         32'h4020: return {28'd0, m_pend};
         32'h4024: return {26'd0, m_state[1:0], 2'b00, m_sel[1:0]};
         32'h4028: return {16'd0, m_count[15:0]};
         default:  return 32'd0;
      endcase
   endfunction

   initial model_reset();

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else model_step();
   end

   always @(negedge clk) begin
      chk("irq_req", {31'd0, irq_req}, {31'd0, m_state == 1});
      chk("in_service", {31'd0, in_service}, {31'd0, m_state == 2});
      chk("irq_sel", {30'd0, irq_sel}, m_sel);
      if (data_bus_mode == 2'b01 &&
          (data_bus_addr == 32'h4020 || data_bus_addr == 32'h4024 || data_bus_addr == 32'h4028))
         chk("bus_read", data_bus_data, m_read(data_bus_addr));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      data_bus_mode = 2'b01;
      data_bus_addr = a;
      #1;
      d = data_bus_data;
      data_bus_mode = 2'b00;
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
   endtask

   task automatic pulse_done();
      irq_done = 1'b1;
      tick(1);
      irq_done = 1'b0;
   endtask

   logic [31:0] d;
   int r;

   initial begin
      reset = 1'b0; irq_sources = 4'hF; irq_mask = 4'hF; irq_ack = 1'b0; irq_done = 1'b0;
      data_bus_addr = 32'd0; data_bus_mode = 2'b00; drv = 32'd0;
      #3;
      chk("rst_req", {31'd0, irq_req}, 32'd0);
      chk("rst_insvc", {31'd0, in_service}, 32'd0);
      rd(32'h4020, d); chk("rst_pending", d, 32'h0);
      rd(32'h4024, d); chk("rst_status", d, 32'h0);
      rd(32'h4028, d); chk("rst_count", d, 32'h0);
      tick(2);
      reset = 1'b1;
      tick(2);

      // Single source, then withdraw by masking, then service.
      irq_sources = 4'b1101;
      tick(1 + LAT);
      rd(32'h4020, d); chk("t27_pending", d, 32'h2);
      chk("t27_req_early", {31'd0, irq_req}, 32'd0);
      tick(1);
      chk("t27_req", {31'd0, irq_req}, 32'd1);
      chk("t27_sel", {30'd0, irq_sel}, 32'd1);
      irq_mask = 4'b1101;
      tick(1);
      chk("t30_req", {31'd0, irq_req}, 32'd0);
      rd(32'h4020, d); chk("t30_pending", d, 32'h2);
      rd(32'h4024, d); chk("t30_status", d, 32'h01);
      irq_mask = 4'hF;
      irq_sources = 4'hF;
      tick(1);
      chk("t30_rereq", {31'd0, irq_req}, 32'd1);
      pulse_ack();
      chk("t30_insvc", {31'd0, in_service}, 32'd1);
      rd(32'h4024, d); chk("t30_status_svc", d, 32'h21);
      pulse_done();

      // Two sources together: priority order and ack count.
      data_bus_mode = 2'b10; data_bus_addr = 32'h4028; drv = 32'd0;
      irq_sources = 4'b1010;
      tick(1);
      data_bus_mode = 2'b00;
      tick(LAT);
      rd(32'h4020, d); chk("t28_pending", d, 32'h5);
      tick(1);
      chk("t28_sel_first", {30'd0, irq_sel}, 32'd2);
      pulse_ack();
      pulse_done();
      tick(1);
      chk("t28_sel_second", {30'd0, irq_sel}, 32'd0);
      pulse_ack();
      pulse_done();
      rd(32'h4028, d); chk("t28_count", d, 32'd2);
      rd(32'h4020, d); chk("t28_pending_end", d, 32'h0);
      irq_sources = 4'hF;
      tick(1);

      // Masked source stays pending until enabled.
      irq_mask = 4'b0001;
      irq_sources = 4'b0111;
      tick(3 + LAT);
      chk("t29_noreq", {31'd0, irq_req}, 32'd0);
      rd(32'h4020, d); chk("t29_pending", d, 32'h8);
      irq_mask = 4'b1000;
      tick(1);
      chk("t29_req", {31'd0, irq_req}, 32'd1);
      chk("t29_sel", {30'd0, irq_sel}, 32'd3);
      pulse_ack();
      pulse_done();
      irq_sources = 4'hF;

      // Set beats write-1-clear in the same cycle; a lone write-1-clear works.
      irq_mask = 4'b0000;
      tick(2);
      irq_sources = 4'b1011;
      tick(LAT);
      data_bus_mode = 2'b10; data_bus_addr = 32'h4020; drv = 32'h4;
      tick(1);
      data_bus_mode = 2'b00;
      rd(32'h4020, d); chk("t31_set_wins", d, 32'h4);
      data_bus_mode = 2'b10;
      tick(1);
      data_bus_mode = 2'b00;
      rd(32'h4020, d); chk("t31_w1c", d, 32'h0);
      irq_sources = 4'hF;
      irq_mask = 4'hF;
      tick(2);

      // Asynchronous reset while servicing.
      irq_sources = 4'b1101;
      tick(2 + LAT);
      pulse_ack();
      chk("t32_insvc_before", {31'd0, in_service}, 32'd1);
      data_bus_mode = 2'b01; data_bus_addr = 32'h4024;
      #1;
      reset = 1'b0;
      #1;
      chk("t32_insvc", {31'd0, in_service}, 32'd0);
      chk("t32_req", {31'd0, irq_req}, 32'd0);
      chk("t32_status", data_bus_data, 32'h0);
      data_bus_addr = 32'h4028;
      #1;
      chk("t32_count", data_bus_data, 32'h0);
      data_bus_mode = 2'b00;
      irq_sources = 4'hF;
      tick(1);
      reset = 1'b1;
      tick(1);

      // Randomized traffic checked every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(7) == 0) irq_sources[i] = ~irq_sources[i];
         if ($urandom_range(15) == 0) irq_mask = 4'($urandom);
         irq_ack  = ($urandom_range(3) == 0);
         irq_done = ($urandom_range(3) == 0);
         r = $urandom_range(7);
         case ($urandom_range(3))
            0: data_bus_addr = 32'h4020;
            1: data_bus_addr = 32'h4024;
            2: data_bus_addr = 32'h4028;
            default: data_bus_addr = 32'h4030;
         endcase
         drv = $urandom;
         if (r < 4) data_bus_mode = 2'b01;
         else if (r == 4) data_bus_mode = 2'b10;
         else data_bus_mode = 2'b00;
         tick(1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
